simple_phase_seq: RTL and testbench
===================================

Name: simple_phase_seq

Overview:
- Multicycle phase sequencer for the SIMPLE 16-bit core.
- Steps each instruction through IF, ID, EX, MEM and WB, and emits one-hot phase enables plus memory and I/O handshakes.
- Stalls on memory wait and on IN/OUT handshakes; handles HLT, run/stop and single-step.
- Sits beside the control decoder and gates its outputs into the datapath by phase.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- TIMEOUT, 255, max consecutive cycles waiting on mem_ready before a timeout error; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; leaves IDLE and begins fetch
- stop  in  1  level; request to pause at next instruction boundary
- step_mode  in  1  1 = pause after every WB
- inst  in  16  instruction register contents, valid from ID onward
- mem_ready  in  1  memory completes the current access this cycle
- in_valid  in  1  external input data available
- out_ready  in  1  external sink accepts output
- phase  out  5  one-hot {WB,MEM,EX,ID,IF}
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for mem_req
- ir_load  out  1  load instruction register
- pc_update  out  1  commit next PC
- in_ack  out  1  input consumed
- out_valid  out  1  output data valid
- busy  out  1  not in IDLE or HALT
- halted  out  1  HLT executed or timeout occurred
- timeout_err  out  1  sticky watchdog error
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset: synchronous, active-high; rst has priority over every other input. It is honoured mid-instruction and mid-wait, and any pending handshake is abandoned. After reset the state is IDLE and every output is 0, including phase, retired and timeout_err.
- States: IDLE, IF, ID, EX, MEM, WB, HALT. phase is one-hot in IF through WB and 0 in IDLE and HALT.
- IDLE: start=1 -> IF next cycle. Otherwise remain in IDLE.
- IF:
  - mem_req=1, mem_we=0 while in IF.
  - When mem_ready=1: ir_load=1 in that same cycle, and the next state is ID.
  - Otherwise stay in IF.
- ID: exactly 1 cycle; decodes inst[15:14] and inst[7:4].
  - Format 11 with opcode 1111 (HLT) -> HALT. No pc_update and no retire.
  - Otherwise -> EX.
- EX: minimum 1 cycle.
  - IN (fmt 11, op 1100): hold in EX until in_valid=1. in_ack pulses 1 cycle in the cycle in_valid is seen, and the transition occurs that same cycle.
  - OUT (fmt 11, op 1101): out_valid=1 throughout EX. Leave in the cycle out_ready=1; out_valid drops the following cycle.
  - Next state is MEM for LD (fmt 00) or ST (fmt 01), otherwise WB.
- MEM:
  - mem_req=1; mem_we=1 only for ST.
  - Hold until mem_ready=1, then go to WB.
- WB: exactly 1 cycle.
  - pc_update=1 and retired increments by 1, wrapping modulo 2^CNT_W.
  - If stop=1 or step_mode=1 -> IDLE; otherwise -> IF.
  - start is ignored outside IDLE.
- HALT:
  - halted=1; only rst exits.
  - start and stop are ignored.
- Watchdog:
  - A wait counter clears on every entry to IF or MEM and counts each cycle mem_ready=0 in those states.
  - Reaching TIMEOUT -> HALT with timeout_err=1 and halted=1.
  - EX I/O waits are not timed.
- Simultaneous events:
  - mem_ready together with rst: rst wins and no ir_load is issued.
  - stop together with step_mode in WB: goes to IDLE (same result).
  - start and stop both high in IDLE: enter IF. stop is then evaluated at the next WB.
- busy is 1 in IF through WB and 0 in IDLE and HALT.

Decomposition:
- Package simple_pkg holds:
  - the state enum;
  - format codes FMT_LD=00, FMT_ST=01, FMT_BR=10, FMT_ALU=11;
  - opcode constants OP_IN=1100, OP_OUT=1101, OP_HLT=1111;
  - the phase bit indices.
- One sub-module, simple_wait_timer:
  - parameterised down-counter with clear, enable and expire;
  - instantiated once for the watchdog.

Test Plan:
- ADD reg-reg (0xC000), mem_ready=1 always, start pulse -> phase IF,ID,EX,WB on consecutive cycles, then IF again. retired=1 after the first WB. pc_update pulses exactly once per 4 cycles.
- LD (0x0000) with mem_ready low for 3 cycles in MEM -> MEM held 4 cycles with mem_req=1 and mem_we=0. ST (0x4000) -> mem_we=1 only in MEM.
- IN (0xC0C0) with in_valid asserted 5 cycles after entering EX -> EX held 6 cycles and in_ack pulses once. OUT (0xC0D0) with out_ready delayed -> out_valid held high until accepted.
- HLT (0xC0F0) -> after ID, halted=1, busy=0, retired unchanged. start pulses afterward have no effect; rst returns to IDLE with retired=0.
- step_mode=1 running ADDs -> returns to IDLE after each WB. Each start retires exactly one instruction.
- TIMEOUT=4, mem_ready stuck at 0 in IF -> HALT after 4 wait cycles with timeout_err=1. Asserting rst mid-MEM forces IDLE on the next cycle with all outputs 0.

Source files
------------

// File: rtl/simple_pkg.sv
// Shared types and constants for the SIMPLE phase sequencer: state and
// instruction-class enums, format/opcode codes, one-hot phase bit positions.
package simple_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LD, C_ST, C_IN, C_OUT, C_HLT
  } cls_t;

  localparam logic [1:0] FMT_LD  = 2'b00;
  localparam logic [1:0] FMT_ST  = 2'b01;
  localparam logic [1:0] FMT_BR  = 2'b10;
  localparam logic [1:0] FMT_ALU = 2'b11;

  localparam logic [3:0] OP_IN  = 4'b1100;
  localparam logic [3:0] OP_OUT = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int PH_W   = 5;
  localparam int PH_IF  = 0;
  localparam int PH_ID  = 1;
  localparam int PH_EX  = 2;
  localparam int PH_MEM = 3;
  localparam int PH_WB  = 4;

  function automatic cls_t decode(input logic [1:0] fmt, input logic [3:0] op);
    cls_t c;
    c = C_ALU;
    if (fmt == FMT_LD)
      c = C_LD;
    else if (fmt == FMT_ST)
      c = C_ST;
    else if (fmt == FMT_ALU) begin
      if (op == OP_IN)
        c = C_IN;
      else if (op == OP_OUT)
        c = C_OUT;
      else if (op == OP_HLT)
        c = C_HLT;
    end
    return c;
  endfunction

  function automatic logic [PH_W-1:0] phase_of(input state_t s);
    logic [PH_W-1:0] p;
    p = '0;
    case (s)
      S_IF:    p[PH_IF]  = 1'b1;
      S_ID:    p[PH_ID]  = 1'b1;
      S_EX:    p[PH_EX]  = 1'b1;
      S_MEM:   p[PH_MEM] = 1'b1;
      S_WB:    p[PH_WB]  = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/simple_phase_seq_if.sv
// Sequencer-side bundle: run control, instruction, memory and I/O handshakes
// in; phase enables, strobes and status out.
interface simple_phase_seq_if
  import simple_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             step_mode;
  logic [15:0]      inst;
  logic             mem_ready;
  logic             in_valid;
  logic             out_ready;
  logic [PH_W-1:0]  phase;
  logic             mem_req;
  logic             mem_we;
  logic             ir_load;
  logic             pc_update;
  logic             in_ack;
  logic             out_valid;
  logic             busy;
  logic             halted;
  logic             timeout_err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, stop, step_mode, inst, mem_ready, in_valid, out_ready,
    output phase, mem_req, mem_we, ir_load, pc_update, in_ack, out_valid,
           busy, halted, timeout_err, retired
  );

  modport slave (
    output start, stop, step_mode, inst, mem_ready, in_valid, out_ready,
    input  phase, mem_req, mem_we, ir_load, pc_update, in_ack, out_valid,
           busy, halted, timeout_err, retired
  );
endinterface

// File: rtl/simple_wait_timer.sv
// Reloadable down-counter watchdog: clear reloads LOAD, en counts one wait cycle,
// expire flags the LOAD-th consecutive counted cycle. LOAD=0 never expires.
module simple_wait_timer #(
  parameter int W    = 8,
  parameter int LOAD = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= W'(LOAD);
    else if (en && cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign expire = (LOAD != 0) && en && (cnt == W'(1));

endmodule

// File: rtl/simple_phase_seq.sv
// Multicycle IF/ID/EX/MEM/WB sequencer for the SIMPLE core: one-hot phase
// enables, memory and I/O handshakes, run/stop/single-step, HLT and watchdog.
module simple_phase_seq
  import simple_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  simple_phase_seq_if.master bus
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t state, nxt;
  cls_t   cls, cls_d;
  logic   wd_clear, wd_en, wd_exp;

  // Class is decoded from inst while in ID and held for the rest of the instruction.
  always_comb cls_d = (state == S_ID) ? decode(bus.inst[15:14], bus.inst[7:4]) : cls;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (bus.start) nxt = S_IF;
      S_IF: begin
        if (wd_exp)             nxt = S_HALT;
        else if (bus.mem_ready) nxt = S_ID;
      end
      S_ID:   nxt = (cls_d == C_HLT) ? S_HALT : S_EX;
      S_EX: begin
        if (cls == C_IN)        nxt = bus.in_valid  ? S_WB : S_EX;
        else if (cls == C_OUT)  nxt = bus.out_ready ? S_WB : S_EX;
        else if (cls == C_LD || cls == C_ST) nxt = S_MEM;
        else                    nxt = S_WB;
      end
      S_MEM: begin
        if (wd_exp)             nxt = S_HALT;
        else if (bus.mem_ready) nxt = S_WB;
      end
      S_WB:   nxt = (bus.stop || bus.step_mode) ? S_IDLE : S_IF;
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  assign wd_en    = (state == S_IF || state == S_MEM) && !bus.mem_ready;
  assign wd_clear = (nxt != state) && (nxt == S_IF || nxt == S_MEM);

  simple_wait_timer #(.W(TW), .LOAD(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .en     (wd_en),
    .expire (wd_exp)
  );

  // Same-cycle strobes; reset suppresses them so an abandoned access never loads.
  assign bus.ir_load = !rst && (state == S_IF) && bus.mem_ready;
  assign bus.in_ack  = !rst && (state == S_EX) && (cls == C_IN) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cls             <= C_ALU;
      bus.phase       <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.pc_update   <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.halted      <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.retired     <= '0;
    end else begin
      state           <= nxt;
      cls             <= cls_d;
      bus.phase       <= phase_of(nxt);
      bus.mem_req     <= (nxt == S_IF) || (nxt == S_MEM);
      bus.mem_we      <= (nxt == S_MEM) && (cls_d == C_ST);
      bus.pc_update   <= (nxt == S_WB);
      bus.out_valid   <= (nxt == S_EX) && (cls_d == C_OUT);
      bus.busy        <= (nxt inside {S_IF, S_ID, S_EX, S_MEM, S_WB});
      bus.halted      <= (nxt == S_HALT);
      if (wd_exp)
        bus.timeout_err <= 1'b1;
      if (state == S_WB)
        bus.retired <= bus.retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_simple_phase_seq.sv
// Directed bench for simple_phase_seq (TIMEOUT=4): walks each instruction class,
// stalls, HLT, single-step, watchdog and reset cases against hand-computed values.
module tb_simple_phase_seq;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nfail = 0;
  int   cnt, ack;

  localparam logic [4:0] P_IF  = 5'b00001;
  localparam logic [4:0] P_ID  = 5'b00010;
  localparam logic [4:0] P_EX  = 5'b00100;
  localparam logic [4:0] P_MEM = 5'b01000;
  localparam logic [4:0] P_WB  = 5'b10000;

  always #5 clk = ~clk;

  simple_phase_seq_if #(.CNT_W(16)) bus ();

  simple_phase_seq #(.CNT_W(16), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.step_mode = 1'b0; bus.inst = '0;
    bus.mem_ready = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    step(); step();
    chk("rst_phase", 32'(bus.phase), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_timeout", 32'(bus.timeout_err), 0);
    chk("rst_retired", 32'(bus.retired), 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_pc_update", 32'(bus.pc_update), 0);
    rst = 1'b0;

    // ADD reg-reg, memory always ready
    bus.inst = 16'hC000; bus.mem_ready = 1'b1; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk("add_if", 32'(bus.phase), 32'(P_IF));
    chk("add_ir_load", 32'(bus.ir_load), 1);
    chk("add_busy", 32'(bus.busy), 1);
    step(); chk("add_id", 32'(bus.phase), 32'(P_ID));
    step(); chk("add_ex", 32'(bus.phase), 32'(P_EX));
    step(); chk("add_wb", 32'(bus.phase), 32'(P_WB));
    chk("add_pc_update", 32'(bus.pc_update), 1);
    chk("add_retired_wb", 32'(bus.retired), 0);
    step(); chk("add_if2", 32'(bus.phase), 32'(P_IF));
    chk("add_retired1", 32'(bus.retired), 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.pc_update) cnt++;
      step();
    end
    chk("add_pcu_count", 32'(cnt), 2);
    chk("add_retired3", 32'(bus.retired), 3);
    bus.stop = 1'b1;
    step(); step(); step(); step();
    chk("stop_idle_phase", 32'(bus.phase), 0);
    chk("stop_idle_busy", 32'(bus.busy), 0);
    chk("stop_retired", 32'(bus.retired), 4);

    // LD with 3 wait cycles in MEM
    bus.inst = 16'h0000; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step(); step(); step();
    chk("ld_mem", 32'(bus.phase), 32'(P_MEM));
    bus.mem_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.phase == P_MEM && bus.mem_req && !bus.mem_we) cnt++;
      step();
    end
    bus.mem_ready = 1'b1;
    if (bus.phase == P_MEM && bus.mem_req && !bus.mem_we) cnt++;
    step();
    chk("ld_mem_cycles", 32'(cnt), 4);
    chk("ld_wb", 32'(bus.phase), 32'(P_WB));
    step();
    chk("ld_retired", 32'(bus.retired), 5);

    // ST: mem_we only in MEM
    bus.inst = 16'h4000; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk("st_if_we", 32'(bus.mem_we), 0);
    chk("st_if_req", 32'(bus.mem_req), 1);
    step(); step();
    chk("st_ex_we", 32'(bus.mem_we), 0);
    step();
    chk("st_mem_we", 32'(bus.mem_we), 1);
    chk("st_mem_req", 32'(bus.mem_req), 1);
    step();
    chk("st_wb_we", 32'(bus.mem_we), 0);
    chk("st_wb_req", 32'(bus.mem_req), 0);
    step();
    chk("st_retired", 32'(bus.retired), 6);

    // IN: in_valid arrives in the 6th EX cycle
    bus.inst = 16'hC0C0; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step(); step();
    cnt = 0; ack = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.phase == P_EX) cnt++;
      if (bus.in_ack) ack++;
      step();
    end
    bus.in_valid = 1'b1; #1;
    if (bus.phase == P_EX) cnt++;
    if (bus.in_ack) ack++;
    step(); bus.in_valid = 1'b0;
    chk("in_ex_cycles", 32'(cnt), 6);
    chk("in_ack_pulses", 32'(ack), 1);
    chk("in_wb", 32'(bus.phase), 32'(P_WB));
    step();
    chk("in_retired", 32'(bus.retired), 7);

    // OUT: sink accepts in the 4th EX cycle
    bus.inst = 16'hC0D0; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step();
    chk("out_id_valid", 32'(bus.out_valid), 0);
    step();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.out_valid && bus.phase == P_EX) cnt++;
      step();
    end
    bus.out_ready = 1'b1;
    if (bus.out_valid && bus.phase == P_EX) cnt++;
    step(); bus.out_ready = 1'b0;
    chk("out_held", 32'(cnt), 4);
    chk("out_drop", 32'(bus.out_valid), 0);
    chk("out_wb", 32'(bus.phase), 32'(P_WB));
    step();
    chk("out_retired", 32'(bus.retired), 8);

    // HLT
    bus.inst = 16'hC0F0; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step(); step();
    chk("hlt_halted", 32'(bus.halted), 1);
    chk("hlt_busy", 32'(bus.busy), 0);
    chk("hlt_phase", 32'(bus.phase), 0);
    chk("hlt_retired", 32'(bus.retired), 8);
    chk("hlt_pc_update", 32'(bus.pc_update), 0);
    bus.start = 1'b1; step(); bus.start = 1'b0; step();
    chk("hlt_start_ignored", 32'(bus.halted), 1);
    chk("hlt_start_phase", 32'(bus.phase), 0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("hlt_rst_halted", 32'(bus.halted), 0);
    chk("hlt_rst_retired", 32'(bus.retired), 0);

    // single-step ADDs
    bus.stop = 1'b0; bus.step_mode = 1'b1; bus.inst = 16'hC000;
    for (int k = 0; k < 2; k++) begin
      bus.start = 1'b1; step(); bus.start = 1'b0;
      step(); step(); step(); step();
      chk("step_idle", 32'(bus.phase), 0);
      chk("step_retired", 32'(bus.retired), 32'(k + 1));
    end

    // watchdog: memory never ready in IF
    bus.step_mode = 1'b0; bus.mem_ready = 1'b0; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.phase == P_IF && !bus.ir_load) cnt++;
      step();
    end
    chk("wd_if_cycles", 32'(cnt), 4);
    chk("wd_halted", 32'(bus.halted), 1);
    chk("wd_timeout", 32'(bus.timeout_err), 1);
    chk("wd_phase", 32'(bus.phase), 0);
    chk("wd_busy", 32'(bus.busy), 0);
    chk("wd_retired", 32'(bus.retired), 2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("wd_rst_timeout", 32'(bus.timeout_err), 0);

    // mem_ready together with rst in IF: no ir_load
    bus.mem_ready = 1'b1; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    rst = 1'b1; #1;
    chk("rst_blocks_ir_load", 32'(bus.ir_load), 0);
    step(); rst = 1'b0;
    chk("rst_if_idle", 32'(bus.phase), 0);

    // reset in the middle of a MEM wait
    bus.inst = 16'h0000; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step(); step(); step();
    chk("rmem_mem", 32'(bus.phase), 32'(P_MEM));
    bus.mem_ready = 1'b0; rst = 1'b1;
    step();
    chk("rmem_phase", 32'(bus.phase), 0);
    chk("rmem_mem_req", 32'(bus.mem_req), 0);
    chk("rmem_busy", 32'(bus.busy), 0);
    chk("rmem_halted", 32'(bus.halted), 0);
    chk("rmem_retired", 32'(bus.retired), 0);
    rst = 1'b0;
    step();
    chk("rmem_stays_idle", 32'(bus.phase), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
